tile_mac_engine: RTL and testbench

TILE_MAC_ENGINE -- requirements
Module: tile_mac_engine

---
 rtl/tile_mac_engine_if.sv | 41 ++++
 rtl/tile_mac_engine.sv | 210 +++++++++++++++++++++
 tb/tb_tile_mac_engine.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_mac_engine_if.sv
// Command, SRAM read-port and result write-port bundle of the tile MAC engine.
// The master drives the command and returns read data; the engine is the slave.
interface tile_mac_engine_if #(
   parameter int DW = 8,
   parameter int KW = 6,
   parameter int AW = 10
);
   logic          start;
   logic [1:0]    op_code;
   logic [KW-1:0] k_len;
   logic [AW-1:0] a_base;
   logic [AW-1:0] b_base;
   logic [AW-1:0] c_base;
   logic [AW-1:0] a_stride;
   logic [AW-1:0] b_stride;
   logic [AW-1:0] c_stride;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] a_dout;
   logic [DW-1:0] b_dout;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_din;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output start, op_code, k_len,
      output a_base, b_base, c_base, a_stride, b_stride, c_stride,
      output a_dout, b_dout,
      input  a_addr, b_addr, c_we, c_addr, c_din, busy, done, err
   );

   modport slave (
      input  start, op_code, k_len,
      input  a_base, b_base, c_base, a_stride, b_stride, c_stride,
      input  a_dout, b_dout,
      output a_addr, b_addr, c_we, c_addr, c_din, busy, done, err
   );
endinterface

// File: rtl/tile_mac_engine.sv
// N x N tile engine: MUL (K-deep dot product), ADD or SUB per element, read from
// two 1-cycle-latency SRAMs and written back one element at a time.
module tile_mac_engine #(
   parameter int DW  = 8,
   parameter int N   = 4,
   parameter int KW  = 6,
   parameter int AW  = 10,
   parameter int SAT = 1
) (
   input logic               clk,
   input logic               rst_n,
   tile_mac_engine_if.slave  bus
);
   localparam int ACCW = 2*DW + KW;
   localparam int IW   = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0]             OP_MUL   = 2'd0;
   localparam logic [1:0]             OP_ADD   = 2'd1;
   localparam logic [1:0]             OP_SUB   = 2'd2;
   localparam logic [1:0]             OP_RSV   = 2'd3;
   localparam logic [KW-1:0]          K_ONE    = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [KW-1:0]          K_ZERO   = {KW{1'b0}};
   localparam logic [IW-1:0]          I_ONE    = {{(IW-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]          LAST_IDX = IW'(N - 1);
   localparam logic signed [ACCW-1:0] MAX_V    = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] MIN_V    = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t                  state_r;
   logic [1:0]              op_r;
   logic [KW-1:0]           keff_r;
   logic [AW-1:0]           a_base_r, b_base_r, c_base_r;
   logic [AW-1:0]           a_stride_r, b_stride_r, c_stride_r;
   logic [IW-1:0]           i_r, j_r;
   logic [KW-1:0]           k_r;
   logic                    inv_pend_r;
   logic                    rd_v_r, data_v_r;
   logic signed [ACCW-1:0]  acc_r;
   logic [AW-1:0]           a_addr_r, b_addr_r, c_addr_r;
   logic [DW-1:0]           c_din_r;
   logic                    c_we_r, busy_r, done_r, err_r;

   logic                    start_ok_s;
   logic [AW-1:0]           i_ext_s, j_ext_s, k_ext_s;
   logic [AW-1:0]           a_next_s, b_next_s, c_next_s;
   logic signed [DW-1:0]    a_s, b_s;
   logic signed [2*DW-1:0]  prod_s;
   logic signed [ACCW-1:0]  term_s, sum_s;

   function automatic logic [DW-1:0] fit_result(input logic signed [ACCW-1:0] v);
      logic [DW-1:0] r;
      if ((SAT != 0) && (v > MAX_V)) begin
         r = MAX_V[DW-1:0];
      end else if ((SAT != 0) && (v < MIN_V)) begin
         r = MIN_V[DW-1:0];
      end else begin
         r = v[DW-1:0];
      end
      return r;
   endfunction

   // Request validity and read/write address generation for the current (i, j, k).
   always_comb begin
      start_ok_s = (bus.op_code != OP_RSV) &&
                   !((bus.op_code == OP_MUL) && (bus.k_len == K_ZERO));
      i_ext_s  = AW'(i_r);
      j_ext_s  = AW'(j_r);
      k_ext_s  = AW'(k_r);
      c_next_s = c_base_r + i_ext_s * c_stride_r + j_ext_s;
      if (op_r == OP_MUL) begin
         a_next_s = a_base_r + i_ext_s * a_stride_r + k_ext_s;
         b_next_s = b_base_r + k_ext_s * b_stride_r + j_ext_s;
      end else begin
         a_next_s = a_base_r + i_ext_s * a_stride_r + j_ext_s;
         b_next_s = b_base_r + i_ext_s * b_stride_r + j_ext_s;
      end
   end

   // Per-read contribution (product, sum or difference) and the running total.
   always_comb begin
      a_s    = bus.a_dout;
      b_s    = bus.b_dout;
      prod_s = (2*DW)'(a_s) * (2*DW)'(b_s);
      case (op_r)
         OP_ADD:  term_s = ACCW'(a_s) + ACCW'(b_s);
         OP_SUB:  term_s = ACCW'(a_s) - ACCW'(b_s);
         default: term_s = ACCW'(prod_s);
      endcase
      sum_s = acc_r + term_s;
   end

   // Read-data pipeline and accumulator; the last term of an element is folded in at WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v_r   <= 1'b0;
         data_v_r <= 1'b0;
         acc_r    <= {ACCW{1'b0}};
      end else begin
         rd_v_r   <= (state_r == ISSUE);
         data_v_r <= rd_v_r;
         if ((state_r == IDLE) || (state_r == WRITE)) begin
            acc_r <= {ACCW{1'b0}};
         end else if (data_v_r) begin
            acc_r <= sum_s;
         end else begin
            acc_r <= acc_r;
         end
      end
   end

   // Control FSM with command latch, element counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         op_r       <= OP_MUL;
         keff_r     <= K_ONE;
         a_base_r   <= {AW{1'b0}};
         b_base_r   <= {AW{1'b0}};
         c_base_r   <= {AW{1'b0}};
         a_stride_r <= {AW{1'b0}};
         b_stride_r <= {AW{1'b0}};
         c_stride_r <= {AW{1'b0}};
         i_r        <= {IW{1'b0}};
         j_r        <= {IW{1'b0}};
         k_r        <= K_ZERO;
         inv_pend_r <= 1'b0;
         a_addr_r   <= {AW{1'b0}};
         b_addr_r   <= {AW{1'b0}};
         c_addr_r   <= {AW{1'b0}};
         c_din_r    <= {DW{1'b0}};
         c_we_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         busy_r     <= (state_r != IDLE);
         done_r     <= (state_r == FIN) || inv_pend_r;
         err_r      <= inv_pend_r;
         c_we_r     <= (state_r == WRITE);
         inv_pend_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  op_r       <= bus.op_code;
                  keff_r     <= (bus.op_code == OP_MUL) ? bus.k_len : K_ONE;
                  a_base_r   <= bus.a_base;
                  b_base_r   <= bus.b_base;
                  c_base_r   <= bus.c_base;
                  a_stride_r <= bus.a_stride;
                  b_stride_r <= bus.b_stride;
                  c_stride_r <= bus.c_stride;
                  i_r        <= {IW{1'b0}};
                  j_r        <= {IW{1'b0}};
                  k_r        <= K_ZERO;
                  if (start_ok_s) begin
                     state_r <= ISSUE;
                  end else begin
                     inv_pend_r <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               a_addr_r <= a_next_s;
               b_addr_r <= b_next_s;
               if (k_r == keff_r - K_ONE) begin
                  k_r     <= K_ZERO;
                  state_r <= DRAIN;
               end else begin
                  k_r <= k_r + K_ONE;
               end
            end
            DRAIN: state_r <= WRITE;
            WRITE: begin
               c_addr_r <= c_next_s;
               c_din_r  <= fit_result(sum_s);
               if (j_r == LAST_IDX) begin
                  j_r <= {IW{1'b0}};
                  if (i_r == LAST_IDX) begin
                     state_r <= FIN;
                  end else begin
                     i_r     <= i_r + I_ONE;
                     state_r <= ISSUE;
                  end
               end else begin
                  j_r     <= j_r + I_ONE;
                  state_r <= ISSUE;
               end
            end
            FIN:     state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.a_addr = a_addr_r;
   assign bus.b_addr = b_addr_r;
   assign bus.c_we   = c_we_r;
   assign bus.c_addr = c_addr_r;
   assign bus.c_din  = c_din_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.err    = err_r;
endmodule

// File: tb/tb_tile_mac_engine.sv
// Directed bench: a saturating and a truncating engine share one pair of SRAM models;
// each step checks results, write counts and done/busy/err timing against hand values.
module tb_tile_mac_engine;
   localparam int DW = 8;
   localparam int N  = 4;
   localparam int KW = 6;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tile_mac_engine_if #(.DW(DW), .KW(KW), .AW(AW)) ifs ();
   tile_mac_engine_if #(.DW(DW), .KW(KW), .AW(AW)) ift ();

   tile_mac_engine #(.DW(DW), .N(N), .KW(KW), .AW(AW), .SAT(1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(ifs));
   tile_mac_engine #(.DW(DW), .N(N), .KW(KW), .AW(AW), .SAT(0)) dut_trn (
      .clk(clk), .rst_n(rst_n), .bus(ift));

   logic [DW-1:0] mem_a  [0:1023];
   logic [DW-1:0] mem_b  [0:1023];
   logic [DW-1:0] mem_cs [0:1023];
   logic [DW-1:0] mem_ct [0:1023];
   int wr_s = 0;
   int wr_t = 0;
   int n_assert = 0;
   int n_fail = 0;

   // SRAM models: read data one cycle after the address, result capture on c_we.
   always @(posedge clk) begin
      ifs.a_dout <= mem_a[ifs.a_addr];
      ifs.b_dout <= mem_b[ifs.b_addr];
      ift.a_dout <= mem_a[ift.a_addr];
      ift.b_dout <= mem_b[ift.b_addr];
      if (ifs.c_we) begin
         mem_cs[ifs.c_addr] <= ifs.c_din;
         wr_s <= wr_s + 1;
      end
      if (ift.c_we) begin
         mem_ct[ift.c_addr] <= ift.c_din;
         wr_t <= wr_t + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input logic [1:0] op, input logic [KW-1:0] kl,
                          input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] cb,
                          input logic [AW-1:0] as, input logic [AW-1:0] bs, input logic [AW-1:0] cs);
      ifs.op_code = op;  ift.op_code = op;
      ifs.k_len = kl;    ift.k_len = kl;
      ifs.a_base = ab;   ift.a_base = ab;
      ifs.b_base = bb;   ift.b_base = bb;
      ifs.c_base = cb;   ift.c_base = cb;
      ifs.a_stride = as; ift.a_stride = as;
      ifs.b_stride = bs; ift.b_stride = bs;
      ifs.c_stride = cs; ift.c_stride = cs;
   endtask

   // Returns #1 after the accept edge (cycle 0).
   task automatic launch(input logic [1:0] op, input logic [KW-1:0] kl,
                         input logic [AW-1:0] ab, input logic [AW-1:0] bb, input logic [AW-1:0] cb,
                         input logic [AW-1:0] as, input logic [AW-1:0] bs, input logic [AW-1:0] cs);
      @(negedge clk);
      set_cmd(op, kl, ab, bb, cb, as, bs, cs);
      ifs.start = 1'b1;
      ift.start = 1'b1;
      @(posedge clk);
      #1;
      ifs.start = 1'b0;
      ift.start = 1'b0;
   endtask

   // Bounded wait for done; optionally pulses a foreign start at cycle inj.
   task automatic run(input int maxc, input int inj, output int d_s, output int d_t,
                      output logic busy1, output logic busy_end, output logic busy_after);
      d_s = -1; d_t = -1; busy1 = 1'b0; busy_end = 1'b0; busy_after = 1'b1;
      for (int c = 1; c <= maxc; c++) begin
         if (c == inj) begin
            @(negedge clk);
            set_cmd(2'd1, 6'd1, 10'd300, 10'd300, 10'd0, 10'd1, 10'd1, 10'd1);
            ifs.start = 1'b1;
            ift.start = 1'b1;
         end
         @(posedge clk);
         #1;
         ifs.start = 1'b0;
         ift.start = 1'b0;
         if (c == 1) busy1 = ifs.busy;
         if (ifs.done && (d_s < 0)) begin
            d_s = c;
            busy_end = ifs.busy;
         end
         if (ift.done && (d_t < 0)) d_t = c;
         if ((d_s > 0) && (c == d_s + 1)) begin
            busy_after = ifs.busy;
            break;
         end
      end
   endtask

   initial begin
      int d_s, d_t, w0, wt0;
      logic b1, be, ba;
      rst_n = 1'b0;
      ifs.start = 1'b0;
      ift.start = 1'b0;
      set_cmd(2'd0, 6'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      for (int i = 0; i < 4; i++) mem_a[5*i] = 8'd1;
      for (int i = 0; i < 16; i++) mem_b[i] = 8'(i + 1);
      mem_a[300] = 8'd100;  mem_b[300] = 8'd100;
      mem_a[301] = 8'h9C;   mem_b[301] = 8'h9C;
      mem_a[400] = 8'd5;    mem_b[400] = 8'd7;
      for (int i = 700; i <= 720; i++) begin
         mem_a[i] = 8'd127;
         mem_b[i] = 8'd127;
      end
      mem_a[1020] = 8'd5;   mem_b[20] = 8'd6;   mem_b[24] = 8'd22;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(ifs.busy), 32'd0);
      chk("rst_done", 32'(ifs.done), 32'd0);
      chk("rst_err", 32'(ifs.err), 32'd0);
      chk("rst_c_we", 32'(ifs.c_we), 32'd0);
      chk("rst_a_addr", 32'(ifs.a_addr), 32'd0);
      chk("rst_b_addr", 32'(ifs.b_addr), 32'd0);
      chk("rst_c_addr", 32'(ifs.c_addr), 32'd0);
      chk("rst_c_din", 32'(ifs.c_din), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // MUL identity x B with a stray start at cycle 10: C = B, done at 97
      w0 = wr_s; wt0 = wr_t;
      launch(2'd0, 6'd4, 10'd0, 10'd0, 10'd200, 10'd4, 10'd4, 10'd4);
      chk("mul_busy_c0", 32'(ifs.busy), 32'd0);
      run(150, 10, d_s, d_t, b1, be, ba);
      chk("mul_done_sat", 32'(d_s), 32'd97);
      chk("mul_done_trn", 32'(d_t), 32'd97);
      chk("mul_busy_c1", 32'(b1), 32'd1);
      chk("mul_busy_fin", 32'(be), 32'd1);
      chk("mul_busy_after", 32'(ba), 32'd0);
      chk("mul_writes_sat", 32'(wr_s - w0), 32'd16);
      chk("mul_writes_trn", 32'(wr_t - wt0), 32'd16);
      for (int e = 0; e < 16; e++) begin
         chk($sformatf("mul_c_sat[%0d]", e), 32'(mem_cs[200+e]), 32'(e + 1));
         chk($sformatf("mul_c_trn[%0d]", e), 32'(mem_ct[200+e]), 32'(e + 1));
      end

      // ADD overflow in both directions
      w0 = wr_s;
      launch(2'd1, 6'd0, 10'd300, 10'd300, 10'd500, 10'd4, 10'd4, 10'd4);
      run(100, 0, d_s, d_t, b1, be, ba);
      chk("add_done", 32'(d_s), 32'd49);
      chk("add_writes", 32'(wr_s - w0), 32'd16);
      chk("add_pos_sat", 32'(mem_cs[500]), 32'h7F);
      chk("add_neg_sat", 32'(mem_cs[501]), 32'h80);
      chk("add_pos_trn", 32'(mem_ct[500]), 32'hC8);
      chk("add_neg_trn", 32'(mem_ct[501]), 32'h38);
      chk("add_zero", 32'(mem_cs[502]), 32'h00);

      // SUB 5-7
      launch(2'd2, 6'd9, 10'd400, 10'd400, 10'd600, 10'd4, 10'd4, 10'd4);
      run(100, 0, d_s, d_t, b1, be, ba);
      chk("sub_done", 32'(d_s), 32'd49);
      chk("sub_sat", 32'(mem_cs[600]), 32'hFE);
      chk("sub_trn", 32'(mem_ct[600]), 32'hFE);

      // MUL k_len=3 on all-127 data
      launch(2'd0, 6'd3, 10'd700, 10'd700, 10'd800, 10'd4, 10'd4, 10'd4);
      run(150, 0, d_s, d_t, b1, be, ba);
      chk("mul127_done", 32'(d_s), 32'd81);
      chk("mul127_sat0", 32'(mem_cs[800]), 32'h7F);
      chk("mul127_sat15", 32'(mem_cs[815]), 32'h7F);
      chk("mul127_trn0", 32'(mem_ct[800]), 32'h03);
      chk("mul127_trn15", 32'(mem_ct[815]), 32'h03);

      // Rejected requests: reserved op, then MUL with k_len=0
      for (int t = 0; t < 2; t++) begin
         w0 = wr_s;
         if (t == 0) launch(2'd3, 6'd4, 10'd0, 10'd0, 10'd0, 10'd4, 10'd4, 10'd4);
         else        launch(2'd0, 6'd0, 10'd0, 10'd0, 10'd0, 10'd4, 10'd4, 10'd4);
         chk($sformatf("inv%0d_err_c0", t), 32'(ifs.err), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("inv%0d_err_c1", t), 32'(ifs.err), 32'd1);
         chk($sformatf("inv%0d_done_c1", t), 32'(ifs.done), 32'd1);
         chk($sformatf("inv%0d_busy_c1", t), 32'(ifs.busy), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("inv%0d_err_c2", t), 32'(ifs.err), 32'd0);
         chk($sformatf("inv%0d_done_c2", t), 32'(ifs.done), 32'd0);
         chk($sformatf("inv%0d_busy_c2", t), 32'(ifs.busy), 32'd0);
         repeat (3) @(posedge clk); #1;
         chk($sformatf("inv%0d_no_write", t), 32'(wr_s - w0), 32'd0);
      end

      // Reset during element 5, then a clean rerun
      w0 = wr_s;
      launch(2'd0, 6'd4, 10'd0, 10'd0, 10'd900, 10'd4, 10'd4, 10'd4);
      repeat (32) @(posedge clk);
      #1;
      chk("abort_writes_before", 32'(wr_s - w0), 32'd5);
      rst_n = 1'b0;
      #1;
      chk("abort_c_we", 32'(ifs.c_we), 32'd0);
      chk("abort_busy_sat", 32'(ifs.busy), 32'd0);
      chk("abort_busy_trn", 32'(ift.busy), 32'd0);
      chk("abort_a_addr", 32'(ifs.a_addr), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_more_writes", 32'(wr_s - w0), 32'd5);
      chk("abort_idle_busy", 32'(ifs.busy), 32'd0);
      w0 = wr_s;
      launch(2'd0, 6'd4, 10'd0, 10'd0, 10'd950, 10'd4, 10'd4, 10'd4);
      run(150, 0, d_s, d_t, b1, be, ba);
      chk("rerun_done", 32'(d_s), 32'd97);
      chk("rerun_writes", 32'(wr_s - w0), 32'd16);
      for (int e = 0; e < 16; e++)
         chk($sformatf("rerun_c[%0d]", e), 32'(mem_cs[950+e]), 32'(e + 1));

      // Address wrap: row 1 of A lands on address 0
      launch(2'd1, 6'd0, 10'd1020, 10'd20, 10'd40, 10'd4, 10'd4, 10'd4);
      run(100, 0, d_s, d_t, b1, be, ba);
      chk("wrap_done", 32'(d_s), 32'd49);
      chk("wrap_c00", 32'(mem_cs[40]), 32'd11);
      chk("wrap_c10", 32'(mem_cs[44]), 32'd23);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
